// File: rtl/river_pkg.sv
// rtl/river_pkg.sv - shared types, constants and row table lookup for the river controller
// Purpose: FSM state type, per-row configuration struct, base row tables and the
//          level-scaled configuration function used while loading rows.
// Ports:   none (package).
package river_pkg;

  localparam int          NUM_ROWS     = 4;
  localparam logic [2:0]  MAX_LEVEL    = 3'd7;
  localparam logic [10:0] RIVER_TOP    = 11'd64;
  localparam int          ROW_H_LOG2   = 5;
  localparam logic [10:0] RIVER_BOTTOM = RIVER_TOP + 11'd128;
  localparam int          SPEED_STEP   = 2;
  localparam int          GAP_STEP     = 8;
  localparam logic [7:0]  MIN_GAP      = 8'd16;
  localparam logic [2:0]  GRACE_FRAMES = 3'd4;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] num;
    logic [7:0] gap;
    logic [4:0] speed;
    logic       dir;
  } row_cfg_t;

  localparam logic [2:0] BASE_NUM   [NUM_ROWS] = '{3'd3, 3'd2, 3'd4, 3'd0};
  localparam logic [7:0] BASE_GAP   [NUM_ROWS] = '{8'd64, 8'd96, 8'd48, 8'd128};
  localparam logic [4:0] BASE_SPEED [NUM_ROWS] = '{5'd3, 5'd6, 5'd20, 5'd10};

  // Speed grows with level and clamps at 31; gap shrinks with level and floors
  // at MIN_GAP. The gap is worked in 9-bit signed so it can go negative before
  // the floor is applied instead of wrapping.
  function automatic row_cfg_t row_cfg(input logic [1:0] row, input logic [2:0] level);
    row_cfg_t          cfg;
    logic [5:0]        spd;
    logic signed [8:0] gap;
    spd = {1'b0, BASE_SPEED[row]} + 6'(level) * 6'(SPEED_STEP);
    gap = $signed({1'b0, BASE_GAP[row]}) - $signed(9'(level) * 9'(GAP_STEP));
    cfg.num   = BASE_NUM[row];
    cfg.dir   = ~row[0];
    cfg.speed = (spd > 6'd31) ? 5'd31 : spd[4:0];
    cfg.gap   = (gap < $signed({1'b0, MIN_GAP})) ? MIN_GAP : gap[7:0];
    return cfg;
  endfunction

endpackage

// File: rtl/drown_judge.sv
// rtl/drown_judge.sv - frame-based drowning detector for the river rows
// Purpose: counts consecutive unsupported frames while the frog is in a river
//          row and pulses o_drown once when the grace count is reached.
// Ports:   i_clk, i_reset (sync, active-high), i_clear (restart), i_enable (RUN),
//          i_frame_tick, i_frog_y[10:0], i_lpad_collision[3:0] (already masked),
//          o_drown (1-cycle pulse, registered).
module drown_judge
  import river_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_enable,
  input  logic                i_frame_tick,
  input  logic [10:0]         i_frog_y,
  input  logic [NUM_ROWS-1:0] i_lpad_collision,
  output logic                o_drown
);

  logic [2:0] r_miss_cnt;
  logic       r_drown;
  logic       w_in_river;
  logic [1:0] w_row;
  logic       w_miss;

  assign w_in_river = (i_frog_y >= RIVER_TOP) && (i_frog_y < RIVER_BOTTOM);
  assign w_row      = 2'((i_frog_y - RIVER_TOP) >> ROW_H_LOG2);
  assign w_miss     = w_in_river && !i_lpad_collision[w_row];

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || !i_enable) begin
      r_miss_cnt <= 3'd0;
      r_drown    <= 1'b0;
    end else begin
      r_drown <= 1'b0;
      if (i_frame_tick) begin
        if (w_miss) begin
          // Saturating count: the pulse fires only on the step into GRACE_FRAMES.
          if (r_miss_cnt != GRACE_FRAMES) begin
            r_miss_cnt <= r_miss_cnt + 3'd1;
            if (r_miss_cnt == GRACE_FRAMES - 3'd1) begin
              r_drown <= 1'b1;
            end
          end
        end else begin
          r_miss_cnt <= 3'd0;
        end
      end
    end
  end

  assign o_drown = r_drown;

endmodule

// File: rtl/river_controller.sv
// rtl/river_controller.sv - configures and sequences the four river lily-pad rows
// Purpose: holds level and per-row configuration, reloads rows on level change or
//          restart (LOAD -> FLUSH -> RUN), and reports frog drowning.
// Ports:   i_clk, i_reset (sync, active-high), i_frame_tick, i_level_up,
//          i_game_restart, i_frog_y[10:0], i_lpad_collision[3:0];
//          o_row_number_lpads, o_row_gap_size, o_row_speed, o_row_direction,
//          o_row_start_y, o_row_reset, o_level, o_cfg_busy, o_drown.
module river_controller
  import river_pkg::*;
(
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_frame_tick,
  input  logic                           i_level_up,
  input  logic                           i_game_restart,
  input  logic [10:0]                    i_frog_y,
  input  logic [NUM_ROWS-1:0]            i_lpad_collision,
  output logic [NUM_ROWS-1:0][2:0]       o_row_number_lpads,
  output logic [NUM_ROWS-1:0][7:0]       o_row_gap_size,
  output logic [NUM_ROWS-1:0][4:0]       o_row_speed,
  output logic [NUM_ROWS-1:0]            o_row_direction,
  output logic [NUM_ROWS-1:0][10:0]      o_row_start_y,
  output logic                           o_row_reset,
  output logic [2:0]                     o_level,
  output logic                           o_cfg_busy,
  output logic                           o_drown
);

  state_t                     r_state;
  state_t                     w_next_state;
  logic [1:0]                 r_row_idx;
  logic [2:0]                 r_level;
  logic                       r_pending;
  logic [NUM_ROWS-1:0][2:0]   r_num;
  logic [NUM_ROWS-1:0][7:0]   r_gap;
  logic [NUM_ROWS-1:0][4:0]   r_speed;
  logic [NUM_ROWS-1:0]        r_dir;
  logic                       w_level_adv;
  row_cfg_t                   w_cfg;
  logic [NUM_ROWS-1:0]        w_coll;
  logic                       w_drown;

  assign w_cfg = row_cfg(r_row_idx, r_level);

  always_comb begin
    w_next_state = r_state;
    w_level_adv  = 1'b0;
    case (r_state)
      ST_LOAD:  if (r_row_idx == 2'd3) w_next_state = ST_FLUSH;
      ST_FLUSH: w_next_state = ST_RUN;
      ST_RUN: begin
        // A level-up requested while busy is honoured on arrival in RUN.
        if (i_level_up || r_pending) begin
          w_next_state = ST_LOAD;
          w_level_adv  = 1'b1;
        end
      end
      default:  w_next_state = ST_LOAD;
    endcase
    if (i_game_restart) begin
      w_next_state = ST_LOAD;
      w_level_adv  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_LOAD;
      r_row_idx <= 2'd0;
      r_level   <= 3'd0;
      r_pending <= 1'b0;
      r_num     <= '0;
      r_gap     <= '0;
      r_speed   <= '0;
      r_dir     <= '0;
    end else begin
      r_state <= w_next_state;
      if (i_game_restart) begin
        r_level   <= 3'd0;
        r_row_idx <= 2'd0;
        r_pending <= 1'b0;
      end else begin
        if (r_state == ST_LOAD) begin
          r_num[r_row_idx]   <= w_cfg.num;
          r_gap[r_row_idx]   <= w_cfg.gap;
          r_speed[r_row_idx] <= w_cfg.speed;
          r_dir[r_row_idx]   <= w_cfg.dir;
          r_row_idx          <= r_row_idx + 2'd1;
        end
        if (w_level_adv) begin
          r_level   <= (r_level == MAX_LEVEL) ? r_level : r_level + 3'd1;
          r_pending <= 1'b0;
          r_row_idx <= 2'd0;
        end else if (i_level_up && (r_state != ST_RUN)) begin
          r_pending <= 1'b1;
        end
      end
    end
  end

  // Rows with no pads cannot support the frog, whatever their flag says.
  always_comb begin
    w_coll = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      w_coll[i] = i_lpad_collision[i] & (r_num[i] != 3'd0);
    end
  end

  drown_judge u_drown_judge (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_clear          (i_game_restart),
    .i_enable         (r_state == ST_RUN),
    .i_frame_tick     (i_frame_tick),
    .i_frog_y         (i_frog_y),
    .i_lpad_collision (w_coll),
    .o_drown          (w_drown)
  );

  always_comb begin
    o_row_start_y = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      o_row_start_y[i] = RIVER_TOP + 11'(i << ROW_H_LOG2);
    end
  end

  assign o_row_number_lpads = r_num;
  assign o_row_gap_size     = r_gap;
  assign o_row_speed        = r_speed;
  assign o_row_direction    = r_dir;
  assign o_level            = r_level;
  assign o_cfg_busy         = (r_state != ST_RUN);
  assign o_row_reset        = (r_state != ST_RUN);
  assign o_drown            = w_drown;

endmodule

// File: tb/tb_river_controller.sv
// tb/tb_river_controller.sv - self-checking bench for river_controller
module tb_river_controller;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_tick = 1'b0;
  logic              level_up = 1'b0;
  logic              game_restart = 1'b0;
  logic [10:0]       frog_y = 11'd0;
  logic [3:0]        lpad_collision = 4'd0;
  logic [3:0][2:0]   row_number_lpads;
  logic [3:0][7:0]   row_gap_size;
  logic [3:0][4:0]   row_speed;
  logic [3:0]        row_direction;
  logic [3:0][10:0]  row_start_y;
  logic              row_reset;
  logic [2:0]        level;
  logic              cfg_busy;
  logic              drown;

  int n_vec = 0;
  int n_err = 0;

  int T_NUM   [4] = '{3, 2, 4, 0};
  int T_GAP   [4] = '{64, 96, 48, 128};
  int T_SPEED [4] = '{3, 6, 20, 10};

  river_controller dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_frame_tick       (frame_tick),
    .i_level_up         (level_up),
    .i_game_restart     (game_restart),
    .i_frog_y           (frog_y),
    .i_lpad_collision   (lpad_collision),
    .o_row_number_lpads (row_number_lpads),
    .o_row_gap_size     (row_gap_size),
    .o_row_speed        (row_speed),
    .o_row_direction    (row_direction),
    .o_row_start_y      (row_start_y),
    .o_row_reset        (row_reset),
    .o_level            (level),
    .o_cfg_busy         (cfg_busy),
    .o_drown            (drown)
  );

  always #5 clk = ~clk;

  logic [67:0] cfg_vec;
  assign cfg_vec = {row_number_lpads, row_gap_size, row_speed, row_direction};

  function automatic logic [67:0] exp_cfg(input int lv);
    logic [3:0][2:0] n;
    logic [3:0][7:0] g;
    logic [3:0][4:0] s;
    logic [3:0]      d;
    int sp;
    int gp;
    for (int i = 0; i < 4; i++) begin
      sp = T_SPEED[i] + 2 * lv;
      if (sp > 31) sp = 31;
      gp = T_GAP[i] - 8 * lv;
      if (gp < 16) gp = 16;
      n[i] = 3'(T_NUM[i]);
      g[i] = 8'(gp);
      s[i] = 5'(sp);
      d[i] = (i % 2 == 0);
    end
    return {n, g, s, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(output int n, output bit ok);
    n = 0;
    while (cfg_busy && n < 50) begin
      step();
      n++;
    end
    ok = !cfg_busy;
  endtask

  task automatic pulse_restart_and_wait();
    int n;
    bit ok;
    game_restart = 1'b1;
    step();
    game_restart = 1'b0;
    wait_run(n, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL restart_timeout: busy=%0b after %0d cycles, required 0", cfg_busy, n);
    end
  endtask

  task automatic test_reset();
    int n;
    bit ok;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_vec++;
    if ({cfg_busy, row_reset, level, drown} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_ctrl: busy/rr/lvl/drown=%b required 1_1_000_0", {cfg_busy, row_reset, level, drown});
    end
    n_vec++;
    if (cfg_vec !== 68'd0) begin
      n_err++;
      $display("FAIL reset_cfg: got %h required 0", cfg_vec);
    end
    n = 0;
    while (cfg_busy && n < 20) begin
      step();
      n++;
      n_vec++;
      if (row_reset !== cfg_busy) begin
        n_err++;
        $display("FAIL reset_rowreset_track: row_reset=%b busy=%b", row_reset, cfg_busy);
      end
    end
    n_vec++;
    if (n !== 5) begin
      n_err++;
      $display("FAIL reset_busy_len: got %0d cycles, required 5", n);
    end
    n_vec++;
    if (row_speed[0] !== 5'(T_SPEED[0])) begin
      n_err++;
      $display("FAIL reset_speed0: got %0d required %0d", row_speed[0], T_SPEED[0]);
    end
    n_vec++;
    if (cfg_vec !== exp_cfg(0)) begin
      n_err++;
      $display("FAIL reset_cfg_l0: got %h required %h", cfg_vec, exp_cfg(0));
    end
    n_vec++;
    for (int i = 0; i < 4; i++) begin
      if (row_start_y[i] !== 11'(64 + 32 * i)) begin
        n_err++;
        $display("FAIL start_y%0d: got %0d required %0d", i, row_start_y[i], 64 + 32 * i);
      end
    end
    wait_run(n, ok);
  endtask

  task automatic test_level_sweep();
    int n;
    int exp_lv;
    for (int k = 1; k <= 8; k++) begin
      exp_lv = (k > 7) ? 7 : k;
      level_up = 1'b1;
      step();
      level_up = 1'b0;
      n_vec++;
      if (cfg_busy !== 1'b1) begin
        n_err++;
        $display("FAIL lvlup_busy_k%0d: got %b required 1", k, cfg_busy);
      end
      n = 1;
      while (cfg_busy && n < 50) begin
        step();
        n++;
      end
      n_vec++;
      if (n !== 6) begin
        n_err++;
        $display("FAIL lvlup_latency_k%0d: got %0d required 6", k, n);
      end
      n_vec++;
      if (level !== 3'(exp_lv)) begin
        n_err++;
        $display("FAIL lvlup_level_k%0d: got %0d required %0d", k, level, exp_lv);
      end
      n_vec++;
      if (cfg_vec !== exp_cfg(exp_lv)) begin
        n_err++;
        $display("FAIL lvlup_cfg_k%0d: got %h required %h", k, cfg_vec, exp_cfg(exp_lv));
      end
    end
    n_vec++;
    if (row_speed[2] !== 5'd31 || row_gap_size[0] !== 8'd16 || row_gap_size[2] !== 8'd16) begin
      n_err++;
      $display("FAIL lvl_max_clamp: spd2=%0d gap0=%0d gap2=%0d required 31 16 16",
               row_speed[2], row_gap_size[0], row_gap_size[2]);
    end
  endtask

  task automatic test_pending();
    int p;
    int rises;
    bit prev;
    for (int it = 0; it < 3; it++) begin
      pulse_restart_and_wait();
      p = 1 + (it % 3);
      if (it == 2) p = $urandom_range(1, 3);
      game_restart = 1'b1;
      step();
      game_restart = 1'b0;
      level_up = 1'b1;
      for (int j = 0; j < p; j++) step();
      level_up = 1'b0;
      rises = 0;
      prev = cfg_busy;
      for (int c = 0; c < 40; c++) begin
        step();
        if (!prev && cfg_busy) rises++;
        prev = cfg_busy;
      end
      n_vec++;
      if (rises !== 1) begin
        n_err++;
        $display("FAIL pending_reloads_p%0d: got %0d required 1", p, rises);
      end
      n_vec++;
      if (level !== 3'd1 || cfg_busy !== 1'b0) begin
        n_err++;
        $display("FAIL pending_level_p%0d: level=%0d busy=%b required 1 0", p, level, cfg_busy);
      end
      n_vec++;
      if (cfg_vec !== exp_cfg(1)) begin
        n_err++;
        $display("FAIL pending_cfg_p%0d: got %h required %h", p, cfg_vec, exp_cfg(1));
      end
    end
  endtask

  task automatic test_restart();
    int n;
    bit ok;
    int busy_seen;
    pulse_restart_and_wait();
    for (int k = 0; k < 3; k++) begin
      level_up = 1'b1;
      step();
      level_up = 1'b0;
      wait_run(n, ok);
    end
    n_vec++;
    if (level !== 3'd3) begin
      n_err++;
      $display("FAIL restart_pre_level: got %0d required 3", level);
    end
    game_restart = 1'b1;
    level_up = 1'b1;
    step();
    game_restart = 1'b0;
    level_up = 1'b0;
    n_vec++;
    if (level !== 3'd0 || cfg_busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart_win: level=%0d busy=%b required 0 1", level, cfg_busy);
    end
    wait_run(n, ok);
    n_vec++;
    if (!ok || cfg_vec !== exp_cfg(0)) begin
      n_err++;
      $display("FAIL restart_cfg: got %h required %h", cfg_vec, exp_cfg(0));
    end
    busy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (cfg_busy) busy_seen++;
    end
    n_vec++;
    if (busy_seen !== 0 || level !== 3'd0) begin
      n_err++;
      $display("FAIL restart_no_extra: busy_cycles=%0d level=%0d required 0 0", busy_seen, level);
    end
  endtask

  task automatic test_drown();
    int pulses;
    int early;
    pulse_restart_and_wait();
    frog_y = 11'd100;
    lpad_collision = 4'b0000;
    pulses = 0;
    early = 0;
    for (int t = 1; t <= 4; t++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (drown) begin
        pulses++;
        if (t < 4) early++;
      end
      step();
      if (drown) pulses++;
    end
    for (int c = 0; c < 4; c++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (drown) pulses++;
    end
    n_vec++;
    if (pulses !== 1 || early !== 0) begin
      n_err++;
      $display("FAIL drown_row1: pulses=%0d early=%0d required 1 0", pulses, early);
    end
    frog_y = 11'd40;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    frog_y = 11'd100;
    pulses = 0;
    for (int t = 1; t <= 4; t++) begin
      lpad_collision = (t == 3) ? 4'b0010 : 4'b0000;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (drown) pulses++;
      step();
      if (drown) pulses++;
    end
    lpad_collision = 4'b0000;
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL drown_supported: pulses=%0d required 0", pulses);
    end
  endtask

  task automatic test_above_river();
    int pulses;
    frog_y = 11'd40;
    lpad_collision = 4'b0000;
    pulses = 0;
    for (int t = 0; t < 10; t++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (drown) pulses++;
      step();
      if (drown) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL drown_above: pulses=%0d required 0", pulses);
    end
  endtask

  task automatic test_random_drown();
    int  cnt;
    int  y;
    int  r;
    bit  exp_d;
    bit  supported;
    frog_y = 11'd40;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    cnt = 0;
    y = 100;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) y = $urandom_range(0, 250);
      frog_y = 11'(y);
      lpad_collision = 4'($urandom & $urandom & $urandom);
      frame_tick = ($urandom_range(0, 2) != 0);
      exp_d = 1'b0;
      if (frame_tick) begin
        if (y >= 64 && y < 192) begin
          r = (y - 64) / 32;
          supported = lpad_collision[r] && (T_NUM[r] != 0);
        end else begin
          supported = 1'b1;
        end
        if (!supported) begin
          if (cnt < 4) begin
            cnt++;
            if (cnt == 4) exp_d = 1'b1;
          end
        end else begin
          cnt = 0;
        end
      end
      step();
      n_vec++;
      if (drown !== exp_d) begin
        n_err++;
        $display("FAIL rand_drown c%0d: y=%0d coll=%b got %b required %b", c, y, lpad_collision, drown, exp_d);
      end
    end
    frame_tick = 1'b0;
    lpad_collision = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_level_sweep();
    test_pending();
    test_restart();
    test_drown();
    test_above_river();
    test_random_drown();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
